// File: rtl/seven_segment_reader.sv
// Monitor for the seconds display bus: debounces the segment pattern, decodes it
// to BCD and flags anything other than a +1 (mod 10) advance or a stalled display.
module seven_segment_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 24_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  led_in,
  output logic [3:0]  digit,
  output logic        digit_valid,
  output logic        invalid,
  output logic        tick,
  output logic        seq_error,
  output logic [15:0] tick_count,
  output logic        stalled
);

  localparam int RUN_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

  logic [6:0]       cand;
  logic [RUN_W-1:0] run;
  logic             done;
  logic             have_prev;
  logic [TMR_W-1:0] timer;

  logic       accept;
  logic       legal_accept;
  logic       dec_legal;
  logic [3:0] dec_digit;
  logic [3:0] succ;

  // Pattern bits are gfedcba; anything outside the ten glyphs is illegal.
  always_comb begin
    dec_digit = 4'd0;
    dec_legal = 1'b1;
    case (led_in)
      7'b0111111: dec_digit = 4'd0;
      7'b0000110: dec_digit = 4'd1;
      7'b1011011: dec_digit = 4'd2;
      7'b1001111: dec_digit = 4'd3;
      7'b1100110: dec_digit = 4'd4;
      7'b1101101: dec_digit = 4'd5;
      7'b1111101: dec_digit = 4'd6;
      7'b0000111: dec_digit = 4'd7;
      7'b1111111: dec_digit = 4'd8;
      7'b1101111: dec_digit = 4'd9;
      default:    dec_legal = 1'b0;
    endcase
  end

  // digit always holds the previous legal glyph, so it doubles as prev.
  assign accept       = (led_in == cand) && (run == RUN_MAX) && !done;
  assign legal_accept = accept && dec_legal;
  assign succ         = (digit == 4'd9) ? 4'd0 : digit + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cand <= 7'd0;
      run  <= '0;
      done <= 1'b0;
    end else if (led_in != cand) begin
      cand <= led_in;
      run  <= '0;
      done <= 1'b0;
    end else begin
      if (run != RUN_MAX) run <= run + 1'b1;
      if (accept) done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      invalid     <= 1'b0;
      tick        <= 1'b0;
      seq_error   <= 1'b0;
      tick_count  <= 16'd0;
      have_prev   <= 1'b0;
    end else begin
      tick      <= 1'b0;
      seq_error <= 1'b0;
      if (legal_accept) begin
        digit       <= dec_digit;
        digit_valid <= 1'b1;
        invalid     <= 1'b0;
        have_prev   <= 1'b1;
        if (have_prev) begin
          if (dec_digit == succ) begin
            tick       <= 1'b1;
            tick_count <= tick_count + 16'd1;
          end else if (dec_digit != digit) begin
            seq_error <= 1'b1;
          end
        end
      end else if (accept) begin
        invalid     <= 1'b1;
        digit_valid <= 1'b0;
      end
    end
  end

  // Only a legal glyph proves the display is alive; illegal accepts do not reset the timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (legal_accept) begin
      timer <= '0;
    end else if (timer != TMR_MAX) begin
      timer <= timer + 1'b1;
    end
  end

  assign stalled = (timer == TMR_MAX);

endmodule

// File: tb/tb_seven_segment_reader.sv
// Scoreboard bench for seven_segment_reader: each driven glyph pushes its predicted
// outputs, which are popped and compared on the edge the pattern gets accepted.
module tb_seven_segment_reader;

  localparam int STABLE = 4;
  localparam int TMO    = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  led_in;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        invalid;
  logic        tick;
  logic        seq_error;
  logic [15:0] tick_count;
  logic        stalled;

  typedef struct packed {
    logic [3:0]  digit;
    logic        dv;
    logic        inv;
    logic        tick;
    logic        serr;
    logic [15:0] count;
  } exp_t;

  exp_t obs;
  exp_t exp_q[$];

  logic [6:0] glyph [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                             7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  int          n_checks = 0;
  int          n_fails  = 0;
  int          tick_seen = 0;
  int          serr_seen = 0;
  int          m_prev;
  logic        m_have_prev;
  logic [3:0]  m_digit;
  logic [15:0] m_count;

  seven_segment_reader #(.STABLE_CYCLES(STABLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .led_in(led_in), .digit(digit), .digit_valid(digit_valid),
    .invalid(invalid), .tick(tick), .seq_error(seq_error), .tick_count(tick_count),
    .stalled(stalled)
  );

  always #5 clk = ~clk;

  assign obs = {digit, digit_valid, invalid, tick, seq_error, tick_count};

  // Pulse counters sample the pre-edge value, so each registered pulse counts once.
  always @(posedge clk) begin
    if (tick) tick_seen <= tick_seen + 1;
    if (seq_error) serr_seen <= serr_seen + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    m_prev      = 0;
    m_have_prev = 1'b0;
    m_digit     = 4'd0;
    m_count     = 16'd0;
  endtask

  // Predict the accept, queue it, drive the pattern and wait until the accept edge has passed.
  task automatic drive_glyph(input logic [6:0] p);
    exp_t e;
    int d;
    d = -1;
    for (int i = 0; i < 10; i++) if (glyph[i] == p) d = i;
    e = '0;
    if (d < 0) begin
      e.digit = m_digit;
      e.inv   = 1'b1;
    end else begin
      e.dv    = 1'b1;
      e.digit = d[3:0];
      if (m_have_prev && d == (m_prev + 1) % 10) begin
        e.tick  = 1'b1;
        m_count = m_count + 16'd1;
      end else if (m_have_prev && d != m_prev) begin
        e.serr = 1'b1;
      end
      m_prev      = d;
      m_have_prev = 1'b1;
      m_digit     = d[3:0];
    end
    e.count = m_count;
    exp_q.push_back(e);
    led_in = p;
    repeat (STABLE + 1) @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    reset  = 1'b1;
    led_in = 7'h7F;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== exp_t'(0)) begin
      n_fails++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs, exp_t'(0));
    end
    n_checks++;
    if (stalled !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL reset_stalled: got %b expected 0", stalled);
    end
    reset = 1'b0;
    model_reset();
    drive_glyph(glyph[0]);
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fails++;
      $display("[TB] FAIL first_accept: got %h expected %h", obs, e);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_sequence();
    exp_t e;
    int t0, s0;
    t0 = tick_seen;
    s0 = serr_seen;
    for (int d = 1; d <= 10; d++) begin
      drive_glyph(glyph[d % 10]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fails++;
        $display("[TB] FAIL seq_step_%0d: got %h expected %h", d % 10, obs, e);
      end
      @(negedge clk);
      n_checks++;
      if (tick !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL tick_width_%0d: got %b expected 0", d % 10, tick);
      end
      repeat (4) @(negedge clk);
    end
    n_checks++;
    if (tick_seen - t0 != 10 || serr_seen - s0 != 0 || tick_count !== 16'd10) begin
      n_fails++;
      $display("[TB] FAIL seq_totals: ticks %0d serr %0d count %0d, expected 10 0 10",
               tick_seen - t0, serr_seen - s0, tick_count);
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    exp_t hold_e;
    int s0;
    for (int d = 1; d <= 3; d++) begin
      drive_glyph(glyph[d]);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fails++;
        $display("[TB] FAIL to_three_%0d: got %h expected %h", d, obs, e);
      end
      repeat (3) @(negedge clk);
    end
    s0 = serr_seen;
    hold_e = '{digit: 4'd3, dv: 1'b1, inv: 1'b0, tick: 1'b0, serr: 1'b0, count: m_count};
    led_in = glyph[8];
    repeat (STABLE - 1) @(negedge clk);
    n_checks++;
    if (obs !== hold_e) begin
      n_fails++;
      $display("[TB] FAIL glitch_hold: got %h expected %h", obs, hold_e);
    end
    drive_glyph(glyph[3]);
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e || serr_seen != s0) begin
      n_fails++;
      $display("[TB] FAIL glitch_return: got %h expected %h serr_pulses %0d",
               obs, e, serr_seen - s0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_invalid();
    exp_t e;
    drive_glyph(7'b0000001);
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fails++;
      $display("[TB] FAIL illegal_glyph: got %h expected %h", obs, e);
    end
    repeat (2) @(negedge clk);
    drive_glyph(glyph[4]);
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fails++;
      $display("[TB] FAIL after_illegal: got %h expected %h", obs, e);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_seq_error();
    exp_t e;
    drive_glyph(glyph[2]);
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fails++;
      $display("[TB] FAIL jump_back: got %h expected %h", obs, e);
    end
    repeat (3) @(negedge clk);
    drive_glyph(glyph[5]);
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fails++;
      $display("[TB] FAIL skip_ahead: got %h expected %h", obs, e);
    end
    @(negedge clk);
    n_checks++;
    if (seq_error !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL serr_width: got %b expected 0", seq_error);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stall_and_reset();
    exp_t e;
    drive_glyph(glyph[0]);
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fails++;
      $display("[TB] FAIL stall_start: got %h expected %h", obs, e);
    end
    repeat (TMO - 1) @(negedge clk);
    n_checks++;
    if (stalled !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL stall_early: got %b expected 0", stalled);
    end
    @(negedge clk);
    n_checks++;
    if (stalled !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL stall_rise: got %b expected 1", stalled);
    end
    drive_glyph(glyph[1]);
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e || stalled !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL stall_clear: got %h stalled %b expected %h stalled 0", obs, stalled, e);
    end
    drive_glyph(glyph[2]);
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fails++;
      $display("[TB] FAIL pre_reset_two: got %h expected %h", obs, e);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== exp_t'(0) || stalled !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL midrun_reset: got %h stalled %b expected 0", obs, stalled);
    end
    reset = 1'b0;
    model_reset();
    drive_glyph(glyph[3]);
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fails++;
      $display("[TB] FAIL post_reset_first: got %h expected %h", obs, e);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    led_in = 7'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_sequence();
    test_glitch();
    test_invalid();
    test_seq_error();
    test_stall_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
